// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage: valid/ready handshake, sync flush, optional 2-entry skid.
// Define PIPE_STAGE_PERF_EN to build the stall/flush performance counters.
module pipe_stage_buf #(
  parameter int                DATA_W    = 32,
  parameter int                PC_W      = 32,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0,
  parameter int                SKID      = 1,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [PC_W-1:0]   out_pc,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Handshake: a beat moves on a side when its valid and ready are both high
  // at the rising edge; a valid producer holds its data until that happens.
  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic [PC_W-1:0]   main_pc_q,    main_pc_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic [PC_W-1:0]   skid_pc_q,    skid_pc_d;
  logic              accept;
  logic              send;

  assign in_ready  = (SKID != 0) ? ~skid_valid_q : (~main_valid_q | out_ready);
  assign accept    = in_valid & in_ready;
  assign send      = main_valid_q & out_ready;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign out_pc    = main_pc_q;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_pc_d    = main_pc_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_pc_d    = skid_pc_q;
    if (flush) begin
      // The pc is kept so branch logic can still read it after the kill.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_data_d  = NOP_VALUE;
    end else if (SKID != 0) begin
      if (!main_valid_q || send) begin
        if (skid_valid_q) begin
          main_valid_d = 1'b1;
          main_data_d  = skid_data_q;
          main_pc_d    = skid_pc_q;
          skid_valid_d = 1'b0;
        end else if (accept) begin
          main_valid_d = 1'b1;
          main_data_d  = in_data;
          main_pc_d    = in_pc;
        end else begin
          main_valid_d = 1'b0;
        end
      end else if (accept) begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
        skid_pc_d    = in_pc;
      end
    end else begin
      if (accept) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
        main_pc_d    = in_pc;
      end else if (send) begin
        main_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      main_valid_q <= 1'b0;
      main_data_q  <= NOP_VALUE;
      main_pc_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_pc_q    <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_pc_q    <= main_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic             killed;

  // A head that leaves on the flush cycle was delivered, not killed.
  assign killed = skid_valid_q | (main_valid_q & ~out_ready);

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (main_valid_q && !out_ready && !(&stall_cnt_q))
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush && killed && !(&flush_cnt_q))
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: skid instance checked by a queue scoreboard every cycle,
// plus a small single-entry instance for the combinational in_ready path.
module tb_pipe_stage_buf;
  localparam int DATA_W = 32;
  localparam int PC_W   = 32;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = 15;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // skid instance
  logic              in_valid = 1'b0, in_ready, flush = 1'b0;
  logic [DATA_W-1:0] in_data = '0, out_data;
  logic [PC_W-1:0]   in_pc = '0, out_pc;
  logic              out_valid, out_ready = 1'b0;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  // single-entry instance
  logic              i0_valid = 1'b0, i0_ready, o0_valid, o0_ready = 1'b0;
  logic [DATA_W-1:0] i0_data = '0, o0_data;
  logic [PC_W-1:0]   i0_pc = '0, o0_pc;
  logic [15:0]       s0_cnt, f0_cnt;

  pipe_stage_buf #(.DATA_W(DATA_W), .PC_W(PC_W), .SKID(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_pc(out_pc),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  pipe_stage_buf #(.DATA_W(DATA_W), .PC_W(PC_W), .SKID(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(i0_valid), .in_ready(i0_ready),
    .in_data(i0_data), .in_pc(i0_pc), .flush(1'b0), .out_valid(o0_valid),
    .out_ready(o0_ready), .out_data(o0_data), .out_pc(o0_pc),
    .stall_cnt(s0_cnt), .flush_cnt(f0_cnt));

  int tests_run = 0;
  int fails = 0;

  // scoreboard: entries {pc, data} pushed on accept, popped on send
  logic [PC_W+DATA_W-1:0] exp_q[$];
  int   exp_stall = 0;
  int   exp_flush = 0;
  int   recv = 0;
  logic last_acc = 1'b0;
  logic m_rdy;
  logic [CNT_W-1:0] es, ef;

  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      exp_stall = 0;
      exp_flush = 0;
      last_acc  = 1'b0;
    end else begin
      m_rdy = (exp_q.size() < 2);
`ifdef PIPE_STAGE_PERF_EN
      es = CNT_W'(exp_stall);
      ef = CNT_W'(exp_flush);
`else
      es = '0;
      ef = '0;
`endif
      tests_run++;
      if (in_ready !== m_rdy) begin
        fails++;
        $display("FAIL sb_in_ready t=%0t got %b exp %b", $time, in_ready, m_rdy);
      end
      tests_run++;
      if (out_valid !== (exp_q.size() != 0)) begin
        fails++;
        $display("FAIL sb_out_valid t=%0t got %b exp %b", $time, out_valid, exp_q.size() != 0);
      end
      if (exp_q.size() != 0) begin
        tests_run++;
        if ({out_pc, out_data} !== exp_q[0]) begin
          fails++;
          $display("FAIL sb_head t=%0t got %h exp %h", $time, {out_pc, out_data}, exp_q[0]);
        end
      end
      tests_run++;
      if (stall_cnt !== es || flush_cnt !== ef) begin
        fails++;
        $display("FAIL sb_counters t=%0t got %0d/%0d exp %0d/%0d", $time, stall_cnt, flush_cnt, es, ef);
      end
      // advance the model across the coming edge
      if (exp_q.size() != 0 && !out_ready && exp_stall < CNT_MAX) exp_stall++;
      if (exp_q.size() != 0 && out_ready) begin
        void'(exp_q.pop_front());
        recv++;
      end
      if (flush) begin
        if (exp_q.size() != 0 && exp_flush < CNT_MAX) exp_flush++;
        exp_q.delete();
      end
      last_acc = in_valid && m_rdy;
      if (last_acc && !flush) exp_q.push_back({in_pc, in_data});
    end
  end

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout got %0d entries exp 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    in_valid = 1'b1; in_data = 32'h55; in_pc = 32'h1234;
    i0_valid = 1'b1; i0_data = 32'h66;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_pc !== '0) begin
      fails++;
      $display("FAIL reset_out got v=%b d=%h pc=%h exp 0/0/0", out_valid, out_data, out_pc);
    end
    tests_run++;
    if (stall_cnt !== '0 || flush_cnt !== '0) begin
      fails++;
      $display("FAIL reset_cnt got %0d/%0d exp 0/0", stall_cnt, flush_cnt);
    end
    tests_run++;
    if (o0_valid !== 1'b0 || o0_data !== '0 || o0_pc !== '0) begin
      fails++;
      $display("FAIL reset_out0 got v=%b d=%h pc=%h exp 0/0/0", o0_valid, o0_data, o0_pc);
    end
    in_valid = 1'b0; i0_valid = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_stream();
    logic [DATA_W-1:0] vals[3];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (i > 0) begin
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== vals[i-1]) begin
          fails++;
          $display("FAIL stream_lag[%0d] got v=%b d=%h exp 1/%h", i - 1, out_valid, out_data, vals[i-1]);
        end
      end
      if (i < 3) begin
        in_valid = 1'b1; in_data = vals[i]; in_pc = 32'h100 + 32'(i);
      end else begin
        in_valid = 1'b0;
      end
    end
    wait_drain();
  endtask

  task automatic test_flush();
    // flush while empty: data forced to bubble, pc kept, nothing counted
    @(posedge clk); #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_pc !== 32'h102) begin
      fails++;
      $display("FAIL flush_empty got v=%b d=%h pc=%h exp 0/0/102", out_valid, out_data, out_pc);
    end
    // flush with both entries held and a new offer pending
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h51; in_pc = 32'h200;
    @(posedge clk); #1; in_data = 32'h52; in_pc = 32'h204;
    @(posedge clk); #1; in_data = 32'h99; in_pc = 32'h208; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0; in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_pc !== 32'h200 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL flush_full got v=%b d=%h pc=%h rdy=%b exp 0/0/200/1", out_valid, out_data, out_pc, in_ready);
    end
    // same-cycle accept on a flush is discarded
    in_valid = 1'b1; in_data = 32'h71; in_pc = 32'h300;
    @(posedge clk); #1; in_data = 32'h72; in_pc = 32'h304; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0; in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || out_pc !== 32'h300) begin
      fails++;
      $display("FAIL flush_accept got v=%b pc=%h exp 0/300", out_valid, out_pc);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_skid();
    int base = recv;
    bit done = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1; in_valid = 1'b1; in_data = 32'hA; in_pc = 32'h400;
    @(posedge clk); #1; in_data = 32'hB; in_pc = 32'h404;
    @(posedge clk); #1; in_data = 32'hC; in_pc = 32'h408;
    tests_run++;
    if (in_ready !== 1'b0 || out_data !== 32'hA) begin
      fails++;
      $display("FAIL skid_full got rdy=%b d=%h exp 0/a", in_ready, out_data);
    end
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL skid_hold got rdy=%b exp 0", in_ready);
    end
    out_ready = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1; in_valid = 1'b0;
        done = 1'b1;
      end
    end
    tests_run++;
    if (!done) begin
      fails++;
      $display("FAIL skid_accept_timeout got 0 exp 1");
      in_valid = 1'b0;
    end
    wait_drain();
    tests_run++;
    if (recv - base !== 3) begin
      fails++;
      $display("FAIL skid_count got %0d exp 3", recv - base);
    end
  endtask

  task automatic test_flush_send();
    int base;
    out_ready = 1'b1;
    @(posedge clk); #1; in_valid = 1'b1; in_data = 32'h61; in_pc = 32'h500;
    @(posedge clk); #1; base = recv; in_data = 32'h62; in_pc = 32'h504; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0; in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || recv - base !== 1) begin
      fails++;
      $display("FAIL flush_send got v=%b recv=%0d exp 0/1", out_valid, recv - base);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_skid0();
    o0_ready = 1'b0;
    @(posedge clk); #1; i0_valid = 1'b1; i0_data = 32'h21; i0_pc = 32'h600;
    @(posedge clk); #1; i0_valid = 1'b0;
    tests_run++;
    if (o0_valid !== 1'b1 || o0_data !== 32'h21 || i0_ready !== 1'b0) begin
      fails++;
      $display("FAIL skid0_stall got v=%b d=%h rdy=%b exp 1/21/0", o0_valid, o0_data, i0_ready);
    end
    o0_ready = 1'b1;
    #1;
    tests_run++;
    if (i0_ready !== 1'b1) begin
      fails++;
      $display("FAIL skid0_comb_ready got %b exp 1", i0_ready);
    end
    i0_valid = 1'b1; i0_data = 32'h23; i0_pc = 32'h604;
    @(posedge clk); #1; i0_valid = 1'b0;
    tests_run++;
    if (o0_valid !== 1'b1 || o0_data !== 32'h23 || o0_pc !== 32'h604) begin
      fails++;
      $display("FAIL skid0_pass got v=%b d=%h pc=%h exp 1/23/604", o0_valid, o0_data, o0_pc);
    end
    @(posedge clk); #1;
    tests_run++;
    if (o0_valid !== 1'b0) begin
      fails++;
      $display("FAIL skid0_empty got %b exp 0", o0_valid);
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (!in_valid || last_acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = $urandom;
        in_pc    = $urandom;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_flush();
    test_skid();
    test_flush_send();
    test_skid0();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
